// File: rtl/hp_arb_pkg.sv
// Shared types and constants for the HP-port read arbiter and its owner FIFO.
package hp_arb_pkg;

  localparam int unsigned OUT_DEPTH_DEF = 4;
  localparam int unsigned DATA_W_DEF    = 64;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned LEN_W         = 4;

  localparam logic [1:0] AXSIZE_8B    = 2'b11;
  localparam logic [1:0] AXBURST_INCR = 2'b01;

  typedef logic [0:0] owner_t;

  typedef enum logic {
    AR_IDLE,
    AR_ISSUE
  } ar_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ar_req_t;

  // Round-robin pick: favoured requester wins a tie, otherwise the sole requester.
  function automatic owner_t rr_pick(input logic [1:0] valid, input owner_t favoured);
    if (valid == 2'b11) return favoured;
    return owner_t'(valid[1]);
  endfunction

endpackage

// File: rtl/hp_rd_arbiter_if.sv
// Requester-side and HP-port AR/R signals bundled for the arbiter.
interface hp_rd_arbiter_if
  import hp_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [1:0][ADDR_W-1:0] rq_araddr;
  logic [1:0][LEN_W-1:0]  rq_arlen;
  logic [1:0]             rq_arvalid;
  logic [1:0]             rq_arready;
  logic [1:0][DATA_W-1:0] rq_rdata;
  logic [1:0][1:0]        rq_rresp;
  logic [1:0]             rq_rlast;
  logic [1:0]             rq_rvalid;
  logic [1:0]             rq_rready;

  logic [ADDR_W-1:0]      M2S_AXI_ARADDR;
  logic [LEN_W-1:0]       M2S_AXI_ARLEN;
  logic [1:0]             M2S_AXI_ARSIZE;
  logic [1:0]             M2S_AXI_ARBURST;
  logic                   M2S_AXI_ARVALID;
  logic                   M2S_AXI_ARREADY;
  logic [DATA_W-1:0]      M2S_AXI_RDATA;
  logic [1:0]             M2S_AXI_RRESP;
  logic                   M2S_AXI_RLAST;
  logic                   M2S_AXI_RVALID;
  logic                   M2S_AXI_RREADY;

  // Arbiter view
  modport slave (
    input  rq_araddr, rq_arlen, rq_arvalid, rq_rready,
    input  M2S_AXI_ARREADY, M2S_AXI_RDATA, M2S_AXI_RRESP, M2S_AXI_RLAST, M2S_AXI_RVALID,
    output rq_arready, rq_rdata, rq_rresp, rq_rlast, rq_rvalid,
    output M2S_AXI_ARADDR, M2S_AXI_ARLEN, M2S_AXI_ARSIZE, M2S_AXI_ARBURST,
    output M2S_AXI_ARVALID, M2S_AXI_RREADY
  );

  // Requesters plus HP port view
  modport master (
    output rq_araddr, rq_arlen, rq_arvalid, rq_rready,
    output M2S_AXI_ARREADY, M2S_AXI_RDATA, M2S_AXI_RRESP, M2S_AXI_RLAST, M2S_AXI_RVALID,
    input  rq_arready, rq_rdata, rq_rresp, rq_rlast, rq_rvalid,
    input  M2S_AXI_ARADDR, M2S_AXI_ARLEN, M2S_AXI_ARSIZE, M2S_AXI_ARBURST,
    input  M2S_AXI_ARVALID, M2S_AXI_RREADY
  );

endinterface

// File: rtl/hp_owner_fifo.sv
// In-order FIFO of burst owners; head steers R beats back to the requester.
module hp_owner_fifo
  import hp_arb_pkg::*;
#(
  parameter int unsigned DEPTH = OUT_DEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  owner_t                 i_push_owner,
  input  logic                   i_pop,
  output owner_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  owner_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_owner;
  end

endmodule

// File: rtl/hp_rd_arbiter.sv
// Two-requester round-robin arbiter for one Zynq HP AXI3 read channel.
// Optional per-requester grant counters on debug when HP_ARB_PERF_EN is defined.
module hp_rd_arbiter
  import hp_arb_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic             fclk,
  input  logic             rst,
  hp_rd_arbiter_if.slave   bus,
  output logic             err_orphan,
  output logic [31:0]      debug
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  ar_state_t  r_state;
  logic [1:0] r_arready;
  logic       r_arvalid;
  ar_req_t    r_ar;
  owner_t     r_rr_fav;
  logic       r_err_orphan;

  owner_t            w_pick;
  owner_t            w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_grant;
  logic              w_push;
  logic              w_pop;
  logic              w_rready;
  logic [1:0]        w_rvalid;
  logic [DATA_W-1:0] w_rdata;

  assign w_pick  = rr_pick(bus.rq_arvalid, r_rr_fav);
  assign w_grant = (r_state == AR_IDLE) && (w_count < CNT_W'(OUT_DEPTH)) && (|bus.rq_arvalid);
  assign w_push  = w_grant & ~w_full;

  // Owner is pushed at grant time so FIFO order always equals AR issue order.
  hp_owner_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_owner_fifo (
    .i_clk        (fclk),
    .i_rst        (rst),
    .i_push       (w_push),
    .i_push_owner (w_pick),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_empty      (w_empty),
    .o_full       (w_full)
  );

  // AR path: grant in IDLE, hold the registered request in ISSUE until ARREADY.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state      <= AR_IDLE;
      r_arready    <= '0;
      r_arvalid    <= 1'b0;
      r_ar         <= '0;
      r_rr_fav     <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_arready <= '0;
      unique case (r_state)
        AR_IDLE: begin
          if (w_grant) begin
            r_arready[w_pick] <= 1'b1;
            r_ar              <= '{addr: bus.rq_araddr[w_pick], len: bus.rq_arlen[w_pick]};
            r_arvalid         <= 1'b1;
            r_rr_fav          <= ~w_pick;
            r_state           <= AR_ISSUE;
          end
        end
        AR_ISSUE: begin
          if (bus.M2S_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= AR_IDLE;
          end
        end
      endcase
      r_err_orphan <= r_err_orphan | (bus.M2S_AXI_RVALID & w_empty);
    end
  end

  assign bus.rq_arready      = r_arready;
  assign bus.M2S_AXI_ARVALID = r_arvalid;
  assign bus.M2S_AXI_ARADDR  = r_ar.addr;
  assign bus.M2S_AXI_ARLEN   = r_ar.len;
  assign bus.M2S_AXI_ARSIZE  = AXSIZE_8B;
  assign bus.M2S_AXI_ARBURST = AXBURST_INCR;
  assign err_orphan          = r_err_orphan;

  // R path is purely combinational from the FIFO head; no beat is ever accepted without an owner.
  always_comb begin
    w_rvalid         = '0;
    w_rvalid[w_head] = bus.M2S_AXI_RVALID & ~w_empty;
  end

  assign w_rready           = bus.rq_rready[w_head] & ~w_empty;
  assign w_pop              = bus.M2S_AXI_RVALID & w_rready & bus.M2S_AXI_RLAST;
  assign w_rdata            = bus.M2S_AXI_RDATA;
  assign bus.M2S_AXI_RREADY = w_rready;
  assign bus.rq_rvalid      = w_rvalid;
  assign bus.rq_rdata       = {w_rdata, w_rdata};
  assign bus.rq_rresp       = {bus.M2S_AXI_RRESP, bus.M2S_AXI_RRESP};
  assign bus.rq_rlast       = {bus.M2S_AXI_RLAST, bus.M2S_AXI_RLAST};

`ifdef HP_ARB_PERF_EN
  logic [15:0] r_grants0;
  logic [15:0] r_grants1;

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_grants0 <= '0;
      r_grants1 <= '0;
    end else if (w_push) begin
      if (w_pick == owner_t'(1)) r_grants1 <= r_grants1 + 16'(1);
      else                       r_grants0 <= r_grants0 + 16'(1);
    end
  end

  assign debug = {r_grants1, r_grants0};
`else
  assign debug = '0;
`endif

endmodule
